mem_wb_pipe_buffer: RTL and testbench

Parametrised MEM/WB pipeline stage for the MIPS core. It replaces the single-entry MEM/WB register with a DEPTH-entry in-order buffer that uses a valid/ready handshake, a synchronous flush and a registered upstream ready. It also sanitises write-back control for cache-miss loads and writes to $zero, and it counts cache-miss loads. It sits between the data-memory/cache stage and the register-file write port.

---
 rtl/mem_wb_pipe_buffer.sv | 114 +++++++++++
 tb/tb_mem_wb_pipe_buffer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_buffer.sv
// MEM/WB stage as a DEPTH-entry in-order buffer with valid/ready handshake,
// write-back sanitising for miss loads and $zero, and a saturating miss counter.
module mem_wb_pipe_buffer #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2,
   parameter int MISS_CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_hit,
   input  logic [DATA_W-1:0]              in_read_data,
   input  logic [DATA_W-1:0]              in_alu_result,
   input  logic [REG_ADDR_W-1:0]          in_write_reg,
   input  logic                           in_reg_write,
   input  logic                           in_mem_to_reg,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_hit,
   output logic [DATA_W-1:0]              out_read_data,
   output logic [DATA_W-1:0]              out_alu_result,
   output logic [REG_ADDR_W-1:0]          out_write_reg,
   output logic                           out_reg_write,
   output logic                           out_mem_to_reg,
   output logic [DATA_W-1:0]              out_wb_data,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic [MISS_CNT_W-1:0]          miss_cnt
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

   typedef struct packed {
      logic                  hit;
      logic [DATA_W-1:0]     readData;
      logic [DATA_W-1:0]     aluResult;
      logic [REG_ADDR_W-1:0] writeReg;
      logic                  regWrite;
      logic                  memToReg;
   } entry_t;

   entry_t           store [DEPTH];
   entry_t           inEntry;
   entry_t           head;
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic             push, pop, missLoad;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // in_ready comes straight from the occupancy register, so a full buffer
   // refuses input even on a cycle where the head is being popped.
   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign missLoad  = in_mem_to_reg & ~in_hit;

   always_comb begin
      inEntry           = '0;
      inEntry.hit       = in_hit;
      inEntry.readData  = in_read_data;
      inEntry.aluResult = in_alu_result;
      inEntry.writeReg  = in_write_reg;
      inEntry.memToReg  = in_mem_to_reg;
      inEntry.regWrite  = in_reg_write & ~missLoad & (in_write_reg != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         miss_cnt <= '0;
      end else begin
         if (flush) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
         end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
         if (push && missLoad && (miss_cnt != '1))
            miss_cnt <= miss_cnt + MISS_CNT_W'(1);
      end
   end

   // Storage is not reset; out_valid masks whatever it holds.
   always_ff @(posedge clk) begin
      if (push) store[wrPtr] <= inEntry;
   end

   assign head           = out_valid ? store[rdPtr] : '0;
   assign out_hit        = head.hit;
   assign out_read_data  = head.readData;
   assign out_alu_result = head.aluResult;
   assign out_write_reg  = head.writeReg;
   assign out_reg_write  = head.regWrite;
   assign out_mem_to_reg = head.memToReg;
   assign out_wb_data    = head.memToReg ? head.readData : head.aluResult;

endmodule

// File: tb/tb_mem_wb_pipe_buffer.sv
// Directed + randomized check of mem_wb_pipe_buffer against a queue-based model.
module tb_mem_wb_pipe_buffer;
   localparam int DW = 32, RW = 5, DEPTH = 2, MW = 2;
   localparam int MISS_MAX = (1 << MW) - 1;

   logic          clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_hit = 0;
   logic          in_reg_write = 0, in_mem_to_reg = 0, out_ready = 0;
   logic [DW-1:0] in_read_data = '0, in_alu_result = '0;
   logic [RW-1:0] in_write_reg = '0;
   logic          in_ready, out_valid, out_hit, out_reg_write, out_mem_to_reg;
   logic [DW-1:0] out_read_data, out_alu_result, out_wb_data;
   logic [RW-1:0] out_write_reg;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic [MW-1:0] miss_cnt;

   mem_wb_pipe_buffer #(.DATA_W(DW), .REG_ADDR_W(RW), .DEPTH(DEPTH), .MISS_CNT_W(MW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_hit(in_hit), .in_read_data(in_read_data), .in_alu_result(in_alu_result),
      .in_write_reg(in_write_reg), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
      .out_read_data(out_read_data), .out_alu_result(out_alu_result),
      .out_write_reg(out_write_reg), .out_reg_write(out_reg_write),
      .out_mem_to_reg(out_mem_to_reg), .out_wb_data(out_wb_data),
      .count(count), .miss_cnt(miss_cnt));

   always #5 clk = ~clk;

   typedef struct {
      bit       hit;
      bit [31:0] rd, alu;
      bit [4:0] wr;
      bit       rw, m2r;
   } ent_t;

   ent_t q[$];
   int   missModel = 0;
   int   nCmp = 0, nBad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      ent_t h;
      h = '{default: 0};
      if (q.size() > 0) h = q[0];
      chk({tag, ":count"},     64'(count),          64'(q.size()));
      chk({tag, ":in_ready"},  64'(in_ready),       64'(q.size() < DEPTH));
      chk({tag, ":out_valid"}, 64'(out_valid),      64'(q.size() > 0));
      chk({tag, ":miss_cnt"},  64'(miss_cnt),       64'(missModel));
      chk({tag, ":hit"},       64'(out_hit),        64'(h.hit));
      chk({tag, ":rd"},        64'(out_read_data),  64'(h.rd));
      chk({tag, ":alu"},       64'(out_alu_result), 64'(h.alu));
      chk({tag, ":wr"},        64'(out_write_reg),  64'(h.wr));
      chk({tag, ":rw"},        64'(out_reg_write),  64'(h.rw));
      chk({tag, ":m2r"},       64'(out_mem_to_reg), 64'(h.m2r));
      chk({tag, ":wb"},        64'(out_wb_data),    64'(h.m2r ? h.rd : h.alu));
   endtask

   task automatic drive(input bit v, input bit hit, input bit [31:0] rd, input bit [31:0] alu,
                        input bit [4:0] wr, input bit rw, input bit m2r);
      in_valid = v; in_hit = hit; in_read_data = rd; in_alu_result = alu;
      in_write_reg = wr; in_reg_write = rw; in_mem_to_reg = m2r;
   endtask

   // One clock: predict from the spec rules, advance the model at the edge,
   // then compare everything on the following falling edge.
   task automatic cycle(input string tag);
      bit   doPush, doPop, isMiss;
      ent_t e;
      doPush = in_valid && (q.size() < DEPTH) && !flush;
      doPop  = (q.size() > 0) && out_ready && !flush;
      isMiss = in_mem_to_reg && !in_hit;
      e.hit = in_hit; e.rd = in_read_data; e.alu = in_alu_result; e.wr = in_write_reg;
      e.m2r = in_mem_to_reg;
      e.rw  = in_reg_write && !isMiss && (in_write_reg != 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (doPop)  void'(q.pop_front());
         if (doPush) q.push_back(e);
      end
      if (doPush && isMiss && missModel < MISS_MAX) missModel++;
      @(negedge clk);
      checkAll(tag);
   endtask

   task automatic resetPulse(input string tag);
      #2 rst_n = 0;
      #1;
      q.delete(); missModel = 0;
      chk({tag, ":async_count"},    64'(count),     64'd0);
      chk({tag, ":async_miss"},     64'(miss_cnt),  64'd0);
      chk({tag, ":async_valid"},    64'(out_valid), 64'd0);
      chk({tag, ":async_in_ready"}, 64'(in_ready),  64'd1);
      chk({tag, ":async_wb"},       64'(out_wb_data), 64'd0);
      #1 rst_n = 1;
   endtask

   initial begin
      #2 checkAll("reset");
      @(negedge clk) rst_n = 1;

      // single entry
      out_ready = 1;
      drive(1, 1, 10, 15, 3, 1, 0); cycle("single_push");
      drive(0, 0, 0, 0, 0, 0, 0);   cycle("single_drain");

      // fill and backpressure
      out_ready = 0;
      drive(1, 1, 0, 1, 4, 1, 0); cycle("fill1");
      drive(1, 1, 0, 2, 4, 1, 0); cycle("fill2");
      drive(1, 1, 0, 3, 4, 1, 0); cycle("fill3_refused");
      drive(0, 0, 0, 0, 0, 0, 0);
      out_ready = 1;
      cycle("pop1"); cycle("pop2"); cycle("pop_empty");

      // miss load then hit load
      drive(1, 0, 32'hDEAD, 5, 7, 1, 1); cycle("miss_load");
      drive(1, 1, 32'hBEEF, 6, 7, 1, 1); cycle("hit_load");
      drive(0, 0, 0, 0, 0, 0, 0);        cycle("miss_drain");

      // $zero write
      drive(1, 1, 0, 42, 0, 1, 0); cycle("zero_reg");
      drive(0, 0, 0, 0, 0, 0, 0);  cycle("zero_drain");

      // flush with a concurrent miss-load push
      out_ready = 0;
      drive(1, 1, 0, 11, 2, 1, 0); cycle("pre_flush1");
      drive(1, 1, 0, 12, 2, 1, 0); cycle("pre_flush2");
      drive(1, 0, 9, 13, 2, 1, 1); flush = 1; out_ready = 1; cycle("flush");
      flush = 0; drive(0, 0, 0, 0, 0, 0, 0); cycle("post_flush");

      // randomized traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom_range(0, 1),
               $urandom_range(0, 1));
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 15) == 0;
         cycle("rand");
         if ($urandom_range(0, 63) == 0) resetPulse("rand_rst");
      end
      flush = 0;

      // saturation then async reset
      resetPulse("pre_sat");
      out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'(i), 32'(i), 5'(i + 1), 1, 1);
         cycle("sat");
      end
      chk("sat_final", 64'(miss_cnt), 64'(MISS_MAX));
      drive(1, 1, 1, 2, 3, 1, 0);
      resetPulse("sat_rst");
      cycle("after_rst");
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
